link_egress: RTL and testbench

LINK_EGRESS -- requirements
Module: link_egress

---
 rtl/link_egress_pkg.sv | 16 +
 rtl/credit_counter.sv | 53 +++++
 rtl/link_egress.sv | 88 ++++++++
 tb/tb_link_egress.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_egress_pkg.sv
// Shared definitions for the link egress block: flit flag positions and FSM encoding.
// Flag bits are expressed as offsets from the MSB so they follow any flit width.
package link_egress_pkg;

    localparam int FLIT_SIZE = 82;
    localparam int HEAD_OFS  = 1;
    localparam int TAIL_OFS  = 2;
    localparam int HEAD_BIT  = FLIT_SIZE - HEAD_OFS;
    localparam int TAIL_BIT  = FLIT_SIZE - TAIL_OFS;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_e;

endpackage

// File: rtl/credit_counter.sv
// Downstream credit counter: decrements on a send, increments on a returned credit.
// A return that would exceed the initial credit count is dropped and flagged (sticky).
module credit_counter #(
    parameter int CREDITS  = 5,
    parameter int CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                dec,
    output logic [CREDIT_W-1:0] count,
    output logic                overflow
);

    localparam logic [CREDIT_W-1:0] MAX_COUNT = CREDIT_W'(CREDITS);

    logic [CREDIT_W-1:0] count_q, count_d;
    logic                err_q, err_d;

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        case ({inc, dec})
            2'b10: begin
                if (count_q == MAX_COUNT) begin
                    err_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            2'b01: begin
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end
            end
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= MAX_COUNT;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count    = count_q;
    assign overflow = err_q;

endmodule

// File: rtl/link_egress.sv
// Credit-based link egress: pops flits from an upstream FIFO onto a registered link,
// keeping packets whole once started (BODY ignores link_en).
module link_egress #(
    parameter int FLIT_SIZE = link_egress_pkg::FLIT_SIZE,
    parameter int CREDITS   = 5,
    parameter int CREDIT_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLIT_SIZE-1:0] fifo_out,
    input  logic                 fifo_empty,
    output logic                 fifo_consume,
    input  logic                 link_en,
    input  logic                 credit_in,
    output logic [FLIT_SIZE-1:0] link_flit,
    output logic                 link_valid,
    output logic [CREDIT_W-1:0]  credits,
    output logic                 pkt_active,
    output logic                 credit_err
);

    import link_egress_pkg::*;

    localparam int HEAD_IDX = FLIT_SIZE - HEAD_OFS;
    localparam int TAIL_IDX = FLIT_SIZE - TAIL_OFS;

    state_e                 state_q, state_d;
    logic [FLIT_SIZE-1:0]   link_flit_q, link_flit_d;
    logic                   link_valid_q, link_valid_d;
    logic [CREDIT_W-1:0]    credit_count;
    logic                   send;
    logic                   is_head;
    logic                   is_tail;

    credit_counter #(
        .CREDITS  (CREDITS),
        .CREDIT_W (CREDIT_W)
    ) u_credit_counter (
        .clk      (clk),
        .rst      (rst),
        .inc      (credit_in),
        .dec      (send),
        .count    (credit_count),
        .overflow (credit_err)
    );

    // rst gates the pop so the upstream FIFO never loses a flit during reset.
    always_comb begin
        is_head = fifo_out[HEAD_IDX];
        is_tail = fifo_out[TAIL_IDX];
        send    = !rst && !fifo_empty && (credit_count != '0) &&
                  ((state_q == BODY) || link_en);
    end

    always_comb begin
        state_d      = state_q;
        link_flit_d  = link_flit_q;
        link_valid_d = 1'b0;
        if (send) begin
            link_flit_d  = fifo_out;
            link_valid_d = 1'b1;
            case (state_q)
                IDLE:    if (is_head && !is_tail) state_d = BODY;
                BODY:    if (is_tail) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            link_flit_q  <= '0;
            link_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            link_flit_q  <= link_flit_d;
            link_valid_q <= link_valid_d;
        end
    end

    assign fifo_consume = send;
    assign link_flit    = link_flit_q;
    assign link_valid   = link_valid_q;
    assign credits      = credit_count;
    assign pkt_active   = (state_q == BODY);

endmodule

// File: tb/tb_link_egress.sv
// Self-checking bench for link_egress: directed scenarios plus a randomized run
// against a packet/credit reference model driven from a queue-based FIFO.
module tb_link_egress;

    localparam int W  = 82;
    localparam int CR = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  fifo_out;
    logic          fifo_empty;
    logic          fifo_consume;
    logic          link_en;
    logic          credit_in;
    logic [W-1:0]  link_flit;
    logic          link_valid;
    logic [CW-1:0] credits;
    logic          pkt_active;
    logic          credit_err;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];

    // Reference model state
    int           m_credits;
    bit           m_in_pkt;
    bit           m_valid;
    bit           m_err;
    bit           m_send;
    logic [W-1:0] m_flit;
    bit           obs_consume;

    always #5 clk = ~clk;

    link_egress #(
        .FLIT_SIZE (W),
        .CREDITS   (CR),
        .CREDIT_W  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_out     (fifo_out),
        .fifo_empty   (fifo_empty),
        .fifo_consume (fifo_consume),
        .link_en      (link_en),
        .credit_in    (credit_in),
        .link_flit    (link_flit),
        .link_valid   (link_valid),
        .credits      (credits),
        .pkt_active   (pkt_active),
        .credit_err   (credit_err)
    );

    function automatic logic [W-1:0] mk_flit(bit h, bit t);
        logic [W-1:0] f;
        f[31:0]   = $urandom();
        f[63:32]  = $urandom();
        f[W-1:64] = (W-64)'($urandom());
        f[W-1]    = h;
        f[W-2]    = t;
        return f;
    endfunction

    task automatic present_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_out   = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic push(bit h, bit t);
        fifo_q.push_back(mk_flit(h, t));
        present_fifo();
    endtask

    task automatic model_reset();
        m_credits = CR;
        m_in_pkt  = 0;
        m_valid   = 0;
        m_err     = 0;
        m_flit    = '0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        link_en   = 1'b0;
        credit_in = 1'b0;
        fifo_q.delete();
        present_fifo();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // One clock cycle: drive, sample fifo_consume before the edge, advance the model.
    task automatic step(bit en, bit cin);
        logic [W-1:0] head;
        bit h, t;
        link_en   = en;
        credit_in = cin;
        present_fifo();
        head   = fifo_out;
        h      = head[W-1];
        t      = head[W-2];
        m_send = (fifo_q.size() != 0) && (m_credits > 0) && (m_in_pkt || en);
        #1 obs_consume = fifo_consume;
        @(posedge clk);
        if (obs_consume && fifo_q.size() != 0) void'(fifo_q.pop_front());
        if (m_send) begin
            m_valid = 1;
            m_flit  = head;
            if (!m_in_pkt && h && !t) m_in_pkt = 1;
            else if (m_in_pkt && t)  m_in_pkt = 0;
        end else begin
            m_valid = 0;
        end
        if (cin && !m_send && m_credits == CR) m_err = 1;
        else m_credits = m_credits + int'(cin) - int'(m_send);
        #1;
        present_fifo();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        link_en   = 1'b1;
        credit_in = 1'b0;
        fifo_q.delete();
        model_reset();
        push(1, 1);
        #3;
        checks++;
        if (fifo_consume !== 1'b0) begin
            errors++; $display("FAIL reset_consume: got %b want 0", fifo_consume);
        end
        @(posedge clk); #1;
        checks++;
        if (link_valid !== 1'b0 || link_flit !== '0 || credits !== CW'(CR) ||
            pkt_active !== 1'b0 || credit_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b flit=%h cr=%0d act=%b err=%b want 0 0 %0d 0 0",
                     link_valid, link_flit, credits, pkt_active, credit_err, CR);
        end
        do_reset();
    endtask

    task automatic test_basic_packet();
        do_reset();
        push(1, 0); push(0, 0); push(0, 1);
        exp_q = fifo_q;
        for (int i = 0; i < 3; i++) begin
            step(1, 0);
            checks++;
            if (obs_consume !== 1'b1) begin
                errors++; $display("FAIL basic_consume[%0d]: got %b want 1", i, obs_consume);
            end
            checks++;
            if (link_valid !== 1'b1 || link_flit !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_flit[%0d]: got v=%b %h want v=1 %h", i, link_valid, link_flit, exp_q[i]);
            end
            checks++;
            if (credits !== CW'(4 - i) || pkt_active !== (i < 2)) begin
                errors++;
                $display("FAIL basic_state[%0d]: got cr=%0d act=%b want cr=%0d act=%b",
                         i, credits, pkt_active, 4 - i, i < 2);
            end
        end
        step(1, 0);
        checks++;
        if (obs_consume !== 1'b0 || link_valid !== 1'b0 || link_flit !== exp_q[2] || credits !== CW'(2)) begin
            errors++;
            $display("FAIL basic_after: got c=%b v=%b cr=%0d want c=0 v=0 cr=2",
                     obs_consume, link_valid, credits);
        end
    endtask

    task automatic test_credit_exhaust();
        do_reset();
        for (int i = 0; i < 7; i++) push(1, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 0);
            checks++;
            if (obs_consume !== 1'b1) begin
                errors++; $display("FAIL exhaust_send[%0d]: got %b want 1", i, obs_consume);
            end
        end
        step(1, 0);
        checks++;
        if (obs_consume !== 1'b0 || credits !== CW'(0)) begin
            errors++; $display("FAIL exhaust_block: got c=%b cr=%0d want c=0 cr=0", obs_consume, credits);
        end
        step(1, 1);
        checks++;
        if (obs_consume !== 1'b0 || credits !== CW'(1)) begin
            errors++; $display("FAIL exhaust_credit_cycle: got c=%b cr=%0d want c=0 cr=1", obs_consume, credits);
        end
        step(1, 0);
        checks++;
        if (obs_consume !== 1'b1 || credits !== CW'(0) || link_valid !== 1'b1) begin
            errors++;
            $display("FAIL exhaust_resume: got c=%b cr=%0d v=%b want c=1 cr=0 v=1", obs_consume, credits, link_valid);
        end
    endtask

    task automatic test_link_en_hold();
        do_reset();
        push(1, 0); push(0, 0); push(0, 1); push(1, 1);
        step(1, 0);
        step(0, 0);
        checks++;
        if (obs_consume !== 1'b1 || pkt_active !== 1'b1) begin
            errors++; $display("FAIL hold_body: got c=%b act=%b want c=1 act=1", obs_consume, pkt_active);
        end
        step(0, 0);
        checks++;
        if (obs_consume !== 1'b1 || pkt_active !== 1'b0) begin
            errors++; $display("FAIL hold_tail: got c=%b act=%b want c=1 act=0", obs_consume, pkt_active);
        end
        step(0, 0);
        checks++;
        if (obs_consume !== 1'b0 || link_valid !== 1'b0) begin
            errors++; $display("FAIL hold_next_head: got c=%b v=%b want c=0 v=0", obs_consume, link_valid);
        end
        step(1, 0);
        checks++;
        if (obs_consume !== 1'b1 || credits !== CW'(1)) begin
            errors++; $display("FAIL hold_release: got c=%b cr=%0d want c=1 cr=1", obs_consume, credits);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        push(1, 1); push(1, 1);
        step(1, 0);
        step(1, 0);
        push(1, 1);
        step(1, 1);
        checks++;
        if (obs_consume !== 1'b1 || credits !== CW'(3)) begin
            errors++; $display("FAIL simul_credit: got c=%b cr=%0d want c=1 cr=3", obs_consume, credits);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        step(0, 1);
        checks++;
        if (credits !== CW'(CR) || credit_err !== 1'b1) begin
            errors++; $display("FAIL overflow_set: got cr=%0d err=%b want cr=%0d err=1", credits, credit_err, CR);
        end
        push(1, 1);
        step(1, 0);
        step(0, 1);
        step(0, 0);
        checks++;
        if (credit_err !== 1'b1 || credits !== CW'(CR)) begin
            errors++; $display("FAIL overflow_sticky: got err=%b cr=%0d want err=1 cr=%0d", credit_err, credits, CR);
        end
        do_reset();
        checks++;
        if (credit_err !== 1'b0) begin
            errors++; $display("FAIL overflow_clear: got err=%b want 0", credit_err);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        push(1, 0); push(0, 0); push(0, 1);
        step(1, 0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (link_valid !== 1'b0 || link_flit !== '0 || credits !== CW'(CR) ||
            pkt_active !== 1'b0 || fifo_consume !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got v=%b flit=%h cr=%0d act=%b c=%b want 0 0 %0d 0 0",
                     link_valid, link_flit, credits, pkt_active, fifo_consume, CR);
        end
        do_reset();
        step(1, 0);
        step(1, 0);
        checks++;
        if (link_valid !== 1'b0 || pkt_active !== 1'b0) begin
            errors++; $display("FAIL async_abandon: got v=%b act=%b want 0 0", link_valid, pkt_active);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 8) begin
                case ($urandom_range(0, 3))
                    0: push(1, 1);
                    1: push(1, 0);
                    2: push(0, 1);
                    default: push(0, 0);
                endcase
            end
            step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) == 0));
            checks++;
            if (obs_consume !== m_send || link_valid !== m_valid || link_flit !== m_flit ||
                credits !== CW'(m_credits) || pkt_active !== m_in_pkt || credit_err !== m_err) begin
                errors++;
                $display("FAIL random[%0d]: got c=%b v=%b cr=%0d act=%b err=%b flit=%h want c=%b v=%b cr=%0d act=%b err=%b flit=%h",
                         n, obs_consume, link_valid, credits, pkt_active, credit_err, link_flit,
                         m_send, m_valid, m_credits, m_in_pkt, m_err, m_flit);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        link_en   = 1'b0;
        credit_in = 1'b0;
        fifo_empty = 1'b1;
        fifo_out  = '0;
        test_reset();
        test_basic_packet();
        test_credit_exhaust();
        test_link_en_hold();
        test_simultaneous();
        test_overflow();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
